// File: rtl/uop_logic_pkg.sv
// uop_logic_pkg: constants and helpers shared by the uop_* logic gates.
//   UOP_WIDTH  default operand width
//   UOP_CNT_W  default match-counter width
//   UOP_MAX_W  widest operand the helper functions accept
//   xnor_vec   bitwise equivalence of two (zero-extended) vectors
`timescale 1ns/1ps
package uop_logic_pkg;

    localparam int unsigned UOP_WIDTH = 1;
    localparam int unsigned UOP_CNT_W = 8;
    localparam int unsigned UOP_MAX_W = 64;

    // Operands narrower than UOP_MAX_W are zero-extended by the caller; the
    // upper result bits are then don't-care.
    function automatic logic [UOP_MAX_W-1:0] xnor_vec(input logic [UOP_MAX_W-1:0] a,
                                                     input logic [UOP_MAX_W-1:0] b);
        return ~(a ^ b);
    endfunction

endpackage

// File: rtl/uop_sat_counter.sv
// uop_sat_counter: up-counter that saturates at all-ones, with synchronous clear.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, count -> 0
//   clr    synchronous clear, takes priority over inc
//   inc    increment request
//   cnt    current count
`timescale 1ns/1ps
module uop_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/uop_nxor.sv
// uop_nxor: bitwise XNOR gate with registered copy, equality flag and a
// saturating count of matching cycles.
//   clk        rising-edge clock for registered outputs
//   rst_n      asynchronous active-low reset
//   aa, bb     operands (WIDTH bits, WIDTH <= UOP_MAX_W)
//   clr        synchronous clear of match_cnt
//   yy         combinational ~(aa ^ bb)
//   eq         combinational &yy (aa == bb)
//   yy_q, eq_q yy and eq registered
//   match_cnt  saturating count of cycles with eq = 1
`timescale 1ns/1ps
module uop_nxor
    import uop_logic_pkg::*;
#(
    parameter int unsigned WIDTH = UOP_WIDTH,
    parameter int unsigned CNT_W = UOP_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] yy,
    input  logic [WIDTH-1:0] aa,
    input  logic [WIDTH-1:0] bb,
    input  logic             clr,
    output logic             eq,
    output logic [WIDTH-1:0] yy_q,
    output logic             eq_q,
    output logic [CNT_W-1:0] match_cnt
);

    logic [UOP_MAX_W-1:0] yy_full;
    logic                 unused_yy_hi;

    assign yy_full = xnor_vec(UOP_MAX_W'(aa), UOP_MAX_W'(bb));
    assign yy      = yy_full[WIDTH-1:0];
    // Upper bits come from zero-extension and carry no information.
    assign unused_yy_hi = ^yy_full;

    // Plain reduction so an X/Z on any operand bit reaches eq unmasked.
    assign eq = &yy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yy_q <= '0;
            eq_q <= 1'b0;
        end else begin
            yy_q <= yy;
            eq_q <= eq;
        end
    end

    uop_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (eq),
        .cnt   (match_cnt)
    );

endmodule

// File: tb/tb_uop_nxor.sv
`timescale 1ns/1ps
module tb_uop_nxor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic clk_run = 1'b0;
    logic cmp_en = 1'b0;

    // WIDTH=1, CNT_W=8
    logic       aa1 = 1'b0, bb1 = 1'b0, yy1, eq1, yyq1, eqq1;
    logic [7:0] cnt1;
    // WIDTH=8, CNT_W=8
    logic [7:0] aa8 = '0, bb8 = '0, yy8, yyq8;
    logic       eq8, eqq8;
    logic [7:0] cnt8;
    // WIDTH=4, CNT_W=3
    logic [3:0] aa4 = '0, bb4 = '0, yy4, yyq4;
    logic       eq4, eqq4;
    logic [2:0] cnt4;

    int n_tests = 0;
    int n_fail = 0;

    uop_nxor #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst_n(rst_n), .yy(yy1), .aa(aa1), .bb(bb1), .clr(clr),
        .eq(eq1), .yy_q(yyq1), .eq_q(eqq1), .match_cnt(cnt1)
    );
    uop_nxor #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .yy(yy8), .aa(aa8), .bb(bb8), .clr(clr),
        .eq(eq8), .yy_q(yyq8), .eq_q(eqq8), .match_cnt(cnt8)
    );
    uop_nxor #(.WIDTH(4), .CNT_W(3)) u_c3 (
        .clk(clk), .rst_n(rst_n), .yy(yy4), .aa(aa4), .bb(bb4), .clr(clr),
        .eq(eq4), .yy_q(yyq4), .eq_q(eqq4), .match_cnt(cnt4)
    );

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: a result bit is 1 exactly when the two operand bits agree.
    function automatic logic [7:0] ref_xnor(input logic [7:0] a, input logic [7:0] b,
                                            input int w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = (a[i] == b[i]) ? 1'b1 : 1'b0;
        return r;
    endfunction

    function automatic int next_cnt(input int c, input bit match, input bit clear,
                                    input int maxv);
        if (clear) return 0;
        if (match) return (c + 1 > maxv) ? maxv : c + 1;
        return c;
    endfunction

    // Model of the registered state.
    logic [7:0] m_yq1, m_yq8, m_yq4;
    logic       m_eq1, m_eq8, m_eq4;
    int         m_c1, m_c8, m_c4;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_yq1 <= '0; m_yq8 <= '0; m_yq4 <= '0;
            m_eq1 <= 1'b0; m_eq8 <= 1'b0; m_eq4 <= 1'b0;
            m_c1 <= 0; m_c8 <= 0; m_c4 <= 0;
        end else begin
            m_yq1 <= ref_xnor(8'(aa1), 8'(bb1), 1);
            m_yq8 <= ref_xnor(aa8, bb8, 8);
            m_yq4 <= ref_xnor(8'(aa4), 8'(bb4), 4);
            m_eq1 <= (aa1 == bb1);
            m_eq8 <= (aa8 == bb8);
            m_eq4 <= (aa4 == bb4);
            m_c1 <= next_cnt(m_c1, aa1 == bb1, clr, 255);
            m_c8 <= next_cnt(m_c8, aa8 == bb8, clr, 255);
            m_c4 <= next_cnt(m_c4, aa4 == bb4, clr, 7);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("w1.yy",   64'(yy1),  64'(ref_xnor(8'(aa1), 8'(bb1), 1)));
            chk("w1.eq",   64'(eq1),  64'(aa1 == bb1));
            chk("w1.yy_q", 64'(yyq1), 64'(m_yq1));
            chk("w1.eq_q", 64'(eqq1), 64'(m_eq1));
            chk("w1.cnt",  64'(cnt1), 64'(m_c1));
            chk("w8.yy",   64'(yy8),  64'(ref_xnor(aa8, bb8, 8)));
            chk("w8.eq",   64'(eq8),  64'(aa8 == bb8));
            chk("w8.yy_q", 64'(yyq8), 64'(m_yq8));
            chk("w8.eq_q", 64'(eqq8), 64'(m_eq8));
            chk("w8.cnt",  64'(cnt8), 64'(m_c8));
            chk("c3.yy",   64'(yy4),  64'(ref_xnor(8'(aa4), 8'(bb4), 4)));
            chk("c3.eq",   64'(eq4),  64'(aa4 == bb4));
            chk("c3.yy_q", 64'(yyq4), 64'(m_yq4));
            chk("c3.eq_q", 64'(eqq4), 64'(m_eq4));
            chk("c3.cnt",  64'(cnt4), 64'(m_c4));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] tt;
    logic [1:0] mt;
    logic [7:0] tab_a8 [8];
    logic [7:0] tab_b8 [8];
    logic [3:0] tab_a4 [8];
    logic [3:0] tab_b4 [8];
    logic       tab_clr [8];

    initial begin
        tt = 4'b1001;
        // Clock stopped and reset asserted: combinational path must still work.
        for (int i = 0; i < 4; i++) begin
            {aa1, bb1} = 2'(i);
            #0.05;
            chk("tt.yy", 64'(yy1), 64'(tt[i]));
            chk("tt.eq", 64'(eq1), 64'(tt[i]));
        end
        chk("rst.yy_q", 64'(yyq1), 64'(0));
        chk("rst.eq_q", 64'(eqq8), 64'(0));
        chk("rst.cnt",  64'(cnt8), 64'(0));

        mt = 2'd0; {aa1, bb1} = mt; #0.05; chk("mt0.yy", 64'(yy1), 64'(1));
        mt = 2'd3; {aa1, bb1} = mt; #0.05; chk("mt3.yy", 64'(yy1), 64'(1));
        mt = 2'd2; {aa1, bb1} = mt; #0.05; chk("mt2.yy", 64'(yy1), 64'(0));

        aa8 = 8'hA5; bb8 = 8'hA4; #0.05;
        chk("a5a4.yy", 64'(yy8), 64'hFE);
        chk("a5a4.eq", 64'(eq8), 64'(0));
        bb8 = 8'hA5; #0.05;
        chk("a5a5.yy", 64'(yy8), 64'hFF);
        chk("a5a5.eq", 64'(eq8), 64'(1));

        // Release reset with all three operand pairs matching.
        aa1 = 1'b1; bb1 = 1'b1;
        aa4 = 4'h9; bb4 = 4'h9;
        #1;
        rst_n = 1'b1;
        clk_run = 1'b1;
        cmp_en = 1'b1;

        tick();
        chk("lat.yy_q", 64'(yyq8), 64'hFF);
        chk("lat.eq_q", 64'(eqq8), 64'(1));
        repeat (4) tick();
        chk("five.cnt8", 64'(cnt8), 64'(5));
        chk("five.cnt3", 64'(cnt4), 64'(5));

        clr = 1'b1;
        tick();
        chk("clr.cnt8", 64'(cnt8), 64'(0));
        clr = 1'b0;
        tick();
        chk("clr1.cnt8", 64'(cnt8), 64'(1));

        repeat (6) tick();
        chk("sat.cnt3", 64'(cnt4), 64'(7));
        repeat (4) tick();
        chk("satk.cnt3", 64'(cnt4), 64'(7));
        chk("run.cnt8", 64'(cnt8), 64'(11));

        bb8 = 8'hA4;
        tick();
        chk("miss.cnt8", 64'(cnt8), 64'(11));
        chk("miss.yy_q", 64'(yyq8), 64'hFE);
        chk("miss.eq_q", 64'(eqq8), 64'(0));

        clr = 1'b1;
        tick();
        clr = 1'b0;
        bb8 = 8'hA5;
        repeat (4) tick();
        chk("four.cnt8", 64'(cnt8), 64'(4));

        // Asynchronous reset between clock edges.
        #3;
        rst_n = 1'b0;
        #0.05;
        chk("arst.cnt8", 64'(cnt8), 64'(0));
        chk("arst.yy_q", 64'(yyq8), 64'(0));
        chk("arst.eq_q", 64'(eqq8), 64'(0));
        chk("arst.cnt3", 64'(cnt4), 64'(0));
        aa8 = 8'h3C; bb8 = 8'hC3; #0.05;
        chk("arst.yy", 64'(yy8), 64'h00);
        chk("arst.eq", 64'(eq8), 64'(0));
        tick();
        chk("hold.cnt8", 64'(cnt8), 64'(0));
        chk("hold.yy_q", 64'(yyq8), 64'(0));
        rst_n = 1'b1;

        tab_a8 = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h0F, 8'h81, 8'h81, 8'h5A};
        tab_b8 = '{8'hA4, 8'h00, 8'h00, 8'h3C, 8'hF0, 8'h81, 8'h81, 8'h5B};
        tab_a4 = '{4'h0, 4'hF, 4'h6, 4'h6, 4'hA, 4'h3, 4'h3, 4'h3};
        tab_b4 = '{4'h0, 4'hF, 4'h9, 4'h6, 4'h5, 4'h3, 4'h3, 4'h2};
        tab_clr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            aa8 = tab_a8[i]; bb8 = tab_b8[i];
            aa4 = tab_a4[i]; bb4 = tab_b4[i];
            aa1 = tab_a8[i][0]; bb1 = tab_b8[i][0];
            clr = tab_clr[i];
            tick();
        end
        clr = 1'b0;
        tick();
        tick();

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
